// File: rtl/alu_input_ctrl.sv
// Operand/opcode entry controller for an ALU driven from slide switches and
// push-buttons: each button is synchronized, debounced and edge-detected.

module alu_input_ctrl_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic             deb_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
    end
  end

  // Level is accepted on the edge where the mismatch count would reach DEBOUNCE_CYCLES.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_MAX) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q      <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
    end
  end

  assign o_press = deb_q & ~deb_prev_q;

endmodule

module alu_input_ctrl #(
  parameter int unsigned NB_DATA         = 8,
  parameter int unsigned NB_OPCODE       = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NB_DATA-1:0]   i_sw,
  input  logic                 i_btn_a,
  input  logic                 i_btn_b,
  input  logic                 i_btn_op,
  output logic [NB_DATA-1:0]   o_op_1,
  output logic [NB_DATA-1:0]   o_op_2,
  output logic [NB_OPCODE-1:0] o_opcode,
  output logic                 o_valid,
  output logic                 o_update,
  output logic [1:0]           o_state
);

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    READY   = 2'd3
  } state_t;

  logic press_a, press_b, press_op;

  alu_input_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_a), .o_press(press_a)
  );
  alu_input_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_b), .o_press(press_b)
  );
  alu_input_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_op (
    .i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_op), .o_press(press_op)
  );

  state_t               state_q, state_d;
  logic [NB_DATA-1:0]   op1_q, op1_d;
  logic [NB_DATA-1:0]   op2_q, op2_d;
  logic [NB_OPCODE-1:0] opc_q, opc_d;
  logic                 valid_q, upd_q, upd_d;

  // Only the highest-priority event that is legal in the current state acts.
  always_comb begin
    state_d = state_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    opc_d   = opc_q;
    upd_d   = 1'b0;
    unique case (state_q)
      WAIT_A: begin
        if (press_a) begin
          op1_d   = i_sw;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (press_a) begin
          op1_d = i_sw;
        end else if (press_b) begin
          op2_d   = i_sw;
          state_d = WAIT_OP;
        end
      end
      WAIT_OP: begin
        if (press_op) begin
          opc_d   = i_sw[NB_OPCODE-1:0];
          state_d = READY;
          upd_d   = 1'b1;
        end
      end
      READY: begin
        if (press_a) begin
          op1_d   = i_sw;
          state_d = WAIT_B;
        end else if (press_b) begin
          op2_d = i_sw;
          upd_d = 1'b1;
        end else if (press_op) begin
          opc_d = i_sw[NB_OPCODE-1:0];
          upd_d = 1'b1;
        end
      end
      default: state_d = WAIT_A;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= WAIT_A;
      op1_q   <= '0;
      op2_q   <= '0;
      opc_q   <= '0;
      valid_q <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      opc_q   <= opc_d;
      valid_q <= (state_d == READY);
      upd_q   <= upd_d;
    end
  end

  assign o_op_1   = op1_q;
  assign o_op_2   = op2_q;
  assign o_opcode = opc_q;
  assign o_valid  = valid_q;
  assign o_update = upd_q;
  assign o_state  = state_q;

endmodule

// File: tb/tb_alu_input_ctrl.sv
// Directed bench for alu_input_ctrl with a short debounce window.

module tb_alu_input_ctrl;

  localparam int unsigned NB_DATA = 8;
  localparam int unsigned NB_OPCODE = 6;
  localparam int unsigned N = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NB_DATA-1:0]   sw;
  logic                 btn_a, btn_b, btn_op;
  logic [NB_DATA-1:0]   op_1, op_2;
  logic [NB_OPCODE-1:0] opcode;
  logic                 valid, update;
  logic [1:0]           state;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  alu_input_ctrl #(
    .NB_DATA(NB_DATA),
    .NB_OPCODE(NB_OPCODE),
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_sw(sw),
    .i_btn_a(btn_a), .i_btn_b(btn_b), .i_btn_op(btn_op),
    .o_op_1(op_1), .o_op_2(op_2), .o_opcode(opcode),
    .o_valid(valid), .o_update(update), .o_state(state)
  );

  // Stimulus only: holds buttons for 'hold' cycles, releases, lets the release settle,
  // and reports how many o_update strobes were seen.
  task automatic press(input logic a, input logic b, input logic op,
                       input logic [NB_DATA-1:0] v, input int unsigned hold,
                       output int unsigned upd);
    upd = 0;
    @(negedge clk);
    sw = v; btn_a = a; btn_b = b; btn_op = op;
    for (int i = 0; i < int'(hold); i++) begin
      @(negedge clk);
      if (update) upd++;
    end
    btn_a = 1'b0; btn_b = 1'b0; btn_op = 1'b0;
    for (int i = 0; i < int'(N) + 6; i++) begin
      @(negedge clk);
      if (update) upd++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; sw = '0; btn_a = 0; btn_b = 0; btn_op = 0;
    repeat (3) @(negedge clk);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if (op_1 !== 8'h00) begin errors++; $display("FAIL reset_op1 got %h want 00", op_1); end
    checks++; if (op_2 !== 8'h00) begin errors++; $display("FAIL reset_op2 got %h want 00", op_2); end
    checks++; if (opcode !== 6'h00) begin errors++; $display("FAIL reset_opcode got %h want 00", opcode); end
    checks++; if (valid !== 1'b0 || update !== 1'b0) begin errors++; $display("FAIL reset_flags got v=%b u=%b want 0/0", valid, update); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_latency;
    int unsigned upd = 0;
    @(negedge clk);
    sw = 8'h0F; btn_a = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (op_1 !== 8'h00 || state !== 2'd0) begin errors++; $display("FAIL latency_early got op1=%h st=%0d want 00/0", op_1, state); end
    @(posedge clk); #1;
    checks++; if (op_1 !== 8'h0F) begin errors++; $display("FAIL latency_op1 got %h want 0f", op_1); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL latency_state got %0d want 1", state); end
    // Held remainder plus release must not produce another event
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (update) upd++; end
    btn_a = 1'b0;
    for (int i = 0; i < int'(N) + 6; i++) begin @(negedge clk); if (update) upd++; end
    checks++; if (upd !== 0 || state !== 2'd1) begin errors++; $display("FAIL latency_single got upd=%0d st=%0d want 0/1", upd, state); end
  endtask

  task automatic test_reload_and_glitch;
    int unsigned upd;
    press(1, 0, 0, 8'h04, 10, upd);
    checks++; if (op_1 !== 8'h04 || state !== 2'd1) begin errors++; $display("FAIL reload_a got op1=%h st=%0d want 04/1", op_1, state); end
    @(negedge clk);
    sw = 8'hAA; btn_b = 1'b1;
    repeat (3) @(negedge clk);
    btn_b = 1'b0;
    repeat (N + 6) @(negedge clk);
    checks++; if (op_2 !== 8'h00 || state !== 2'd1) begin errors++; $display("FAIL glitch_b got op2=%h st=%0d want 00/1", op_2, state); end
  endtask

  task automatic test_full_sequence;
    int unsigned upd;
    press(0, 1, 0, 8'h05, 10, upd);
    checks++; if (op_2 !== 8'h05 || state !== 2'd2 || valid !== 1'b0) begin errors++; $display("FAIL seq_b got op2=%h st=%0d v=%b want 05/2/0", op_2, state, valid); end
    press(1, 0, 0, 8'h99, 10, upd);
    checks++; if (op_1 !== 8'h04 || state !== 2'd2) begin errors++; $display("FAIL seq_a_ignored got op1=%h st=%0d want 04/2", op_1, state); end
    press(0, 0, 1, 8'h22, 10, upd);
    checks++; if (opcode !== 6'h22 || state !== 2'd3 || valid !== 1'b1) begin errors++; $display("FAIL seq_op got opc=%h st=%0d v=%b want 22/3/1", opcode, state, valid); end
    checks++; if (upd !== 1) begin errors++; $display("FAIL seq_update got %0d strobes want 1", upd); end
    checks++; if (op_1 !== 8'h04 || op_2 !== 8'h05) begin errors++; $display("FAIL seq_operands got %h/%h want 04/05", op_1, op_2); end
  endtask

  task automatic test_ready_updates;
    int unsigned upd;
    press(0, 0, 1, 8'hE4, 10, upd);
    checks++; if (opcode !== 6'h24 || state !== 2'd3) begin errors++; $display("FAIL ready_op got opc=%h st=%0d want 24/3", opcode, state); end
    checks++; if (upd !== 1) begin errors++; $display("FAIL ready_op_update got %0d want 1", upd); end
    press(0, 1, 0, 8'h77, 10, upd);
    checks++; if (op_2 !== 8'h77 || state !== 2'd3 || upd !== 1) begin errors++; $display("FAIL ready_b got op2=%h st=%0d upd=%0d want 77/3/1", op_2, state, upd); end
  endtask

  task automatic test_simultaneous;
    int unsigned upd;
    press(1, 0, 1, 8'hD3, 10, upd);
    checks++; if (op_1 !== 8'hD3) begin errors++; $display("FAIL simul_op1 got %h want d3", op_1); end
    checks++; if (opcode !== 6'h24) begin errors++; $display("FAIL simul_opcode got %h want 24", opcode); end
    checks++; if (state !== 2'd1 || valid !== 1'b0) begin errors++; $display("FAIL simul_state got st=%0d v=%b want 1/0", state, valid); end
  endtask

  task automatic test_async_reset;
    int unsigned upd;
    press(0, 1, 0, 8'h31, 10, upd);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL pre_reset_state got %0d want 2", state); end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++; if (state !== 2'd0 || op_1 !== 8'h00 || op_2 !== 8'h00 || opcode !== 6'h00 || valid !== 1'b0 || update !== 1'b0)
      begin errors++; $display("FAIL async_reset got st=%0d %h/%h/%h v=%b u=%b want all 0", state, op_1, op_2, opcode, valid, update); end
    // Button held through reset release must yield exactly one event afterwards
    sw = 8'h5A; btn_a = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    upd = 0;
    for (int i = 0; i < 10; i++) @(negedge clk);
    btn_a = 1'b0;
    repeat (N + 6) @(negedge clk);
    checks++; if (op_1 !== 8'h5A || state !== 2'd1) begin errors++; $display("FAIL held_reset got op1=%h st=%0d want 5a/1", op_1, state); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_reload_and_glitch();
    test_full_sequence();
    test_ready_updates();
    test_simultaneous();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_input_ctrl.md
ALU_INPUT_CTRL -- requirements
Module: alu_input_ctrl

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 8, operand width and switch-bus width.
REQ-002 The block SHALL have parameter NB_OPCODE, default 6, opcode width, taken from i_sw[NB_OPCODE-1:0].
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable cycles required before a button level is accepted (minimum 2).
REQ-004 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-005 i_reset  input  1  asynchronous, active-high reset.
REQ-006 i_sw  input  NB_DATA  raw slide-switch value, asynchronous to i_clk.
REQ-007 i_btn_a / i_btn_b / i_btn_op  input  1 each  raw push-buttons: load operand 1, load operand 2, load opcode.
REQ-008 o_op_1 / o_op_2  output  NB_DATA each  latched operands, drive the ALU i_op_1 / i_op_2.
REQ-009 o_opcode  output  NB_OPCODE  latched opcode, drives the ALU i_opcode.
REQ-010 o_valid  output  1  high while state is READY.
REQ-011 o_update  output  1  one-cycle strobe when the ALU input set becomes or stays valid with new content.
REQ-012 o_state  output  2  current FSM state for LEDs: WAIT_A=0, WAIT_B=1, WAIT_OP=2, READY=3.

Function
REQ-013 Each button SHALL pass through its own 2-flop synchronizer before any other use.
REQ-014 Per button, a counter SHALL increment each cycle the synchronized level differs from the debounced level, clear to 0 when equal, and the debounced level SHALL take the synchronized value on the edge the counter would reach DEBOUNCE_CYCLES.
REQ-015 A synchronized pulse shorter than DEBOUNCE_CYCLES cycles SHALL never change the debounced level.
REQ-016 A press event SHALL be a one-cycle rising edge of the debounced level; a held button SHALL yield exactly one event; releases SHALL yield no event.
REQ-017 Latency: with the raw button first sampled high at edge 1 and held, the register/state update SHALL occur at edge 3+DEBOUNCE_CYCLES.
REQ-018 i_sw SHALL be sampled directly (no synchronizer) on the same edge the update occurs; the user keeps switches static while pressing.
REQ-019 WAIT_A: press A -> o_op_1 <= i_sw, go WAIT_B; B/OP presses ignored.
REQ-020 WAIT_B: press B -> o_op_2 <= i_sw, go WAIT_OP; press A -> reload o_op_1, stay WAIT_B; OP ignored.
REQ-021 WAIT_OP: press OP -> o_opcode <= i_sw[NB_OPCODE-1:0], go READY, o_update=1 that cycle; A/B presses ignored.
REQ-022 READY: press A -> reload o_op_1, go WAIT_B, o_valid drops; press B -> reload o_op_2, stay READY, o_update=1; press OP -> reload o_opcode, stay READY, o_update=1.
REQ-023 Simultaneous events in one cycle: priority A > B > OP; only the highest-priority event legal in the current state acts, the rest are discarded.
REQ-024 o_valid SHALL be a registered decode of state (high exactly when o_state==3); o_update SHALL be registered, asserted the cycle after the triggering edge for exactly one cycle.
REQ-025 Operand/opcode registers SHALL hold their value in every cycle without an accepting event.

Reset
REQ-026 While i_reset is high, independent of i_clk: state WAIT_A, o_op_1=0, o_op_2=0, o_opcode=0, o_valid=0, o_update=0, o_state=0, all synchronizers, debounced levels and counters 0.
REQ-027 Reset asserted mid-sequence or in READY SHALL discard partial entries; a button held through reset release SHALL produce one event after debounce (debounced level restarts at 0).

Verification (DEBOUNCE_CYCLES=4)
REQ-028 i_sw=0x0F, press A held 10 cycles -> o_op_1=0x0F at edge 7, o_state=1, single event only.
REQ-029 Full sequence A=0x04, B=0x05, OP=0x22 -> o_valid=1, o_state=3, o_update one cycle, outputs 0x04/0x05/0x22 (ALU result 0xFF).
REQ-030 Glitch of 3 synchronized cycles on i_btn_b in WAIT_B -> no change to o_op_2 or state.
REQ-031 In READY, A and OP pressed same cycle with i_sw=0xD3 -> o_op_1=0xD3, o_opcode unchanged, o_state=1, o_valid=0.
REQ-032 In READY, press OP with i_sw=0xE4 -> o_opcode=0x24 (upper bits dropped), state stays READY, o_update one cycle.
REQ-033 i_reset pulsed asynchronously in WAIT_OP -> all outputs 0 immediately, o_state=0.
